// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic_lights controller, its command master and benches.
package traffic_lights_pkg;

  localparam int unsigned CMD_TYPE_W = 3;
  localparam int unsigned LIST_DEPTH = 5;

  typedef enum logic [CMD_TYPE_W-1:0] {
    CMD_ON           = 3'd0,
    CMD_OFF          = 3'd1,
    CMD_NOTRANSITION = 3'd2,
    CMD_SET_GREEN    = 3'd3,
    CMD_SET_RED      = 3'd4,
    CMD_SET_YELLOW   = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'd0,
    OP_ON      = 2'd1,
    OP_OFF     = 2'd2,
    OP_BLINK   = 2'd3
  } req_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } cmd_state_t;

endpackage

// File: rtl/traffic_lights_cmd_master_if.sv
// Request handshake and controller command bus of traffic_lights_cmd_master.
interface traffic_lights_cmd_master_if #(
  parameter int unsigned TIME_W = 16
);
  import traffic_lights_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [TIME_W-1:0]     req_green_i;
  logic [TIME_W-1:0]     req_red_i;
  logic [TIME_W-1:0]     req_yellow_i;
  logic [CMD_TYPE_W-1:0] cmd_type_o;
  logic                  cmd_valid_o;
  logic [TIME_W-1:0]     cmd_data_o;
  logic                  busy_o;

  modport master (
    input  req_valid_i, req_op_i, req_green_i, req_red_i, req_yellow_i,
    output req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_green_i, req_red_i, req_yellow_i,
    input  req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o
  );

endinterface

// File: rtl/traffic_lights_cmd_master.sv
// Expands one high-level request into an ordered, gap-spaced traffic_lights command sequence.
// Optional `TL_CMD_SKIP_UNCHANGED_EN: omit SET_* commands whose value matches the last one sent.
module traffic_lights_cmd_master
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP = 1,
  parameter int unsigned TIME_W  = 16
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  traffic_lights_cmd_master_if.master        bus
);

  localparam int unsigned GAP_W = (CMD_GAP > 1) ? $clog2(CMD_GAP + 1) : 1;

  typedef logic [TIME_W-1:0] time_t;

  function automatic time_t clamp(input time_t t);
    return (t == '0) ? time_t'(1) : t;
  endfunction

  cmd_state_t       state_q, state_d;
  cmd_type_t        type_q [LIST_DEPTH];
  cmd_type_t        type_d [LIST_DEPTH];
  time_t            data_q [LIST_DEPTH];
  time_t            data_d [LIST_DEPTH];
  logic [2:0]       idx_q, idx_d, last_q, last_d, k;
  logic [GAP_W-1:0] gap_q, gap_d;
  time_t            g_cl, r_cl, y_cl;
  logic             send_g, send_r, send_y;

  logic             cmd_valid_q;
  cmd_type_t        cmd_type_q;
  time_t            cmd_data_q;
  logic             busy_q;
  logic             ready_q;

  assign g_cl = clamp(bus.req_green_i);
  assign r_cl = clamp(bus.req_red_i);
  assign y_cl = clamp(bus.req_yellow_i);

`ifdef TL_CMD_SKIP_UNCHANGED_EN
  time_t shadow_g_q, shadow_r_q, shadow_y_q;

  assign send_g = (g_cl != shadow_g_q);
  assign send_r = (r_cl != shadow_r_q);
  assign send_y = (y_cl != shadow_y_q);

  // Shadows track what the controller has actually been told, so update on the issuing edge.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shadow_g_q <= '0;
      shadow_r_q <= '0;
      shadow_y_q <= '0;
    end else if (state_d == ST_ISSUE) begin
      case (type_d[idx_d])
        CMD_SET_GREEN:  shadow_g_q <= data_d[idx_d];
        CMD_SET_RED:    shadow_r_q <= data_d[idx_d];
        CMD_SET_YELLOW: shadow_y_q <= data_d[idx_d];
        default:        ;
      endcase
    end
  end
`else
  assign send_g = 1'b1;
  assign send_r = 1'b1;
  assign send_y = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    k       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i && ready_q) begin
          unique case (req_op_t'(bus.req_op_i))
            OP_PROGRAM: begin
              type_d[k] = CMD_NOTRANSITION; data_d[k] = '0; k = k + 3'd1;
              if (send_g) begin type_d[k] = CMD_SET_GREEN;  data_d[k] = g_cl; k = k + 3'd1; end
              if (send_r) begin type_d[k] = CMD_SET_RED;    data_d[k] = r_cl; k = k + 3'd1; end
              if (send_y) begin type_d[k] = CMD_SET_YELLOW; data_d[k] = y_cl; k = k + 3'd1; end
              type_d[k] = CMD_ON; data_d[k] = '0; k = k + 3'd1;
            end
            OP_ON:    begin type_d[0] = CMD_ON;           data_d[0] = '0; k = 3'd1; end
            OP_OFF:   begin type_d[0] = CMD_OFF;          data_d[0] = '0; k = 3'd1; end
            OP_BLINK: begin type_d[0] = CMD_NOTRANSITION; data_d[0] = '0; k = 3'd1; end
          endcase
          last_d  = k - 3'd1;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (idx_q == last_q) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
          if (CMD_GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(CMD_GAP - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_ISSUE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // List storage needs no reset: it is always rewritten before it is read.
  always_ff @(posedge clk_i) begin
    type_q <= type_d;
    data_q <= data_d;
  end

  // Outputs are registered from next-state so the first pulse follows the handshake by one cycle.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      gap_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_ON;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      cmd_valid_q <= (state_d == ST_ISSUE);
      cmd_type_q  <= (state_d == ST_ISSUE) ? type_d[idx_d] : CMD_ON;
      cmd_data_q  <= (state_d == ST_ISSUE) ? data_d[idx_d] : '0;
      busy_q      <= (state_d != ST_IDLE);
      ready_q     <= (state_d == ST_IDLE);
    end
  end

  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.cmd_type_o  = cmd_type_q;
  assign bus.cmd_data_o  = cmd_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.req_ready_o = ready_q;

endmodule

// File: doc/traffic_lights_cmd_master.md
Name: traffic_lights_cmd_master

Overview:
Command initiator for the traffic_lights controller's cmd_type/cmd_valid/cmd_data interface. It accepts one high-level request over a valid/ready handshake and expands it into the correctly ordered sequence of single-cycle controller commands, with a programmable idle gap between commands. It sits between the system configuration logic (register file or CPU bridge) and traffic_lights. Its outputs connect directly to cmd_*_i of traffic_lights.

Parameters:
CMD_GAP, 1, idle cycles (cmd_valid_o low) inserted between consecutive commands of one sequence; 0 means back-to-back.
TIME_W, 16, width of time fields and cmd_data_o.

Ports:
clk_i  input  1  clock
srst_i  input  1  synchronous reset, active-high
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when req_valid_i && req_ready_o
req_op_i  input  2  0=PROGRAM, 1=ON, 2=OFF, 3=BLINK
req_green_i  input  TIME_W  green time, used by PROGRAM
req_red_i  input  TIME_W  red time, used by PROGRAM
req_yellow_i  input  TIME_W  yellow time, used by PROGRAM
cmd_type_o  output  3  command type to traffic_lights
cmd_valid_o  output  1  command strobe, one cycle per command
cmd_data_o  output  TIME_W  command data
busy_o  output  1  sequence in progress

Behaviour:
- Clock is clk_i; reset is synchronous, active-high, on srst_i. All outputs are registered.
- Reset values: cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, busy_o=0, req_ready_o=1. FSM returns to IDLE.
- Command codes: ON=0, OFF=1, NOTRANSITION=2, SET_GREEN=3, SET_RED=4, SET_YELLOW=5. Codes 6 and 7 are never issued.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: req_ready_o=1. On handshake, latch op and times, build the command list, go to ISSUE, and set busy_o=1.
  - ISSUE: drive cmd_valid_o=1 for exactly one cycle with the current entry. Then:
    - if more entries remain and CMD_GAP>0, go to GAP;
    - if more entries remain and CMD_GAP=0, stay in ISSUE with the next entry;
    - if this was the last entry, go to IDLE.
  - GAP: cmd_valid_o=0. A counter runs CMD_GAP cycles, then the FSM goes to ISSUE.
- Command lists:
  - PROGRAM: NOTRANSITION(0), SET_GREEN(g), SET_RED(r), SET_YELLOW(y), ON(0). Five commands.
  - ON: ON(0).
  - OFF: OFF(0).
  - BLINK: NOTRANSITION(0).
- Latency: the first cmd_valid_o pulse occurs on the cycle after the handshake cycle. Total PROGRAM duration is 5 + 4*CMD_GAP cycles.
- On the last pulse, busy_o falls and req_ready_o rises at the next edge. A new request can therefore be accepted on the cycle after the last pulse.
- When cmd_valid_o=0, cmd_data_o=0 and cmd_type_o=0.
- Time fields of 0 are clamped to 1 on latch; traffic_lights requires nonzero times. Other values pass unchanged, with no width change.
- req_valid_i while busy is ignored: it is not queued and ready stays low. Request fields are sampled only at the handshake, so changes during a sequence have no effect.
- srst_i mid-sequence: the sequence aborts at that edge, with no further pulses and no partial command. A command strobed in the same cycle as reset is still seen by the consumer only if it was already registered before the edge.
- req_op_i values are all defined; no illegal-op handling is needed.

Optional Feature:
TL_CMD_SKIP_UNCHANGED_EN.
- Defined: the block keeps shadow registers of the last issued green/red/yellow values. These reset to 0, which is never a legal post-clamp value, so the first PROGRAM always sends all three. In PROGRAM, any SET_* whose clamped value equals its shadow is omitted from the list. NOTRANSITION and ON are always sent. Shadows update when the corresponding SET_* pulse issues.
- Undefined: no shadow registers; PROGRAM always issues all five commands.

Decomposition:
- traffic_lights_pkg holds:
  - enum cmd_type_t: CMD_ON, CMD_OFF, CMD_NOTRANSITION, CMD_SET_GREEN, CMD_SET_RED, CMD_SET_YELLOW;
  - enum req_op_t: OP_PROGRAM, OP_ON, OP_OFF, OP_BLINK;
  - constant CMD_TYPE_W=3.
- This package is shared with traffic_lights and its bench.
- No sub-module; the gap counter and list index are small enough to stay inline.

Test Plan:
- Reset, then PROGRAM g=10 r=20 y=3, CMD_GAP=1 -> pulses at cycles +1,+3,+5,+7,+9: types 2,3,4,5,0 with data 0,10,20,3,0. req_ready_o=1 again at cycle +10.
- CMD_GAP=0, PROGRAM g=5 r=5 y=5 -> five consecutive-cycle pulses (types 2,3,4,5,0). busy_o is high for exactly 5 cycles.
- PROGRAM g=0 r=7 y=0 -> SET_GREEN data=1, SET_RED data=7, SET_YELLOW data=1.
- OFF request, and a BLINK request held valid while busy -> single pulse type 1. The BLINK is accepted only after ready rises, then a single pulse of type 2.
- srst_i asserted after the 2nd pulse of a PROGRAM -> no further pulses, all outputs 0, req_ready_o=1 the cycle after reset deasserts.
- TL_CMD_SKIP_UNCHANGED_EN: PROGRAM 10/20/3, then PROGRAM 10/25/3 -> the second sequence is types 2,4,0 only, with SET_RED data=25.
